polyshift_r_unit: RTL and testbench

POLYSHIFT_R_UNIT -- requirements
Module: polyshift_r

---
 rtl/polyshift_r_unit_if.sv | 25 ++
 rtl/polyshift_r_unit.sv | 78 +++++++
 tb/tb_polyshift_r_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/polyshift_r_unit_if.sv
// Operand/result bundle for polyshift_r_unit: the master drives operands, the slave returns
// the registered shift result.
interface polyshift_r_unit_if #(
  parameter int WORD_WIDTH = 8
) ();
  localparam int SHIFT_W = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] d_i;
  logic [WORD_WIDTH-2:0] c_i;
  logic [SHIFT_W-1:0]    shift_size_i;
  logic [1:0]            shift_type_i;
  logic                  valid_i;
  logic [WORD_WIDTH-1:0] d_o;
  logic                  valid_o;

  modport master (
    output d_i, c_i, shift_size_i, shift_type_i, valid_i,
    input  d_o, valid_o
  );

  modport slave (
    input  d_i, c_i, shift_size_i, shift_type_i, valid_i,
    output d_o, valid_o
  );
endinterface

// File: rtl/polyshift_r_unit.sv
// Registered right shifter: logical, arithmetic, rotate-through-extension (RCR) and rotate.
// The result is one word of a type-specific double-width extension, shifted by log2 mux stages.
module polyshift_r_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  polyshift_r_unit_if.slave   bus
);
  localparam int SHIFT_W = $clog2(WORD_WIDTH);
  localparam int EXT_W   = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {
    SHIFT_LOGIC = 2'd0,
    SHIFT_ARITH = 2'd1,
    SHIFT_RCR   = 2'd2,
    SHIFT_ROR   = 2'd3
  } shift_type_e;

  logic [EXT_W-1:0]      ext_s;
  logic [EXT_W-1:0]      stage_s [0:SHIFT_W];
  logic [WORD_WIDTH-1:0] result_s;
  logic [WORD_WIDTH-1:0] d_d, d_q;
  logic                  valid_d, valid_q;

  // Upper half of the extension supplies the bits that enter from the MSB side.
  always_comb begin
    ext_s = {{WORD_WIDTH{1'b0}}, bus.d_i};
    case (shift_type_e'(bus.shift_type_i))
      SHIFT_LOGIC: ext_s = {{WORD_WIDTH{1'b0}}, bus.d_i};
      SHIFT_ARITH: ext_s = {{WORD_WIDTH{bus.d_i[WORD_WIDTH-1]}}, bus.d_i};
      SHIFT_RCR:   ext_s = {1'b0, bus.c_i, bus.d_i};
      SHIFT_ROR:   ext_s = {bus.d_i, bus.d_i};
      default:     ext_s = {{WORD_WIDTH{1'b0}}, bus.d_i};
    endcase
  end

  // Stage k moves the extension right by 2^k when shift bit k is set; total shift never
  // exceeds WORD_WIDTH-1, so the zero fill at the top never reaches the low word.
  always_comb begin
    stage_s[0] = ext_s;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (bus.shift_size_i[k]) begin
        stage_s[k+1] = stage_s[k] >> (1 << k);
      end else begin
        stage_s[k+1] = stage_s[k];
      end
    end
    result_s = stage_s[SHIFT_W][WORD_WIDTH-1:0];
  end

  // Capture a new result on accepted operations; otherwise hold the word and drop valid.
  always_comb begin
    d_d     = d_q;
    valid_d = 1'b0;
    if (bus.valid_i) begin
      d_d     = result_s;
      valid_d = 1'b1;
    end else begin
      d_d     = d_q;
      valid_d = 1'b0;
    end
  end

  // Output registers, cleared asynchronously so no pre-reset result survives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q     <= {WORD_WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  assign bus.d_o     = d_q;
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_polyshift_r_unit.sv
// Scoreboard bench for polyshift_r_unit (WORD_WIDTH=8): stimulus pushes expected words,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_polyshift_r_unit;
  localparam int W = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] exp_q [$];

  polyshift_r_unit_if #(.WORD_WIDTH(W)) bus ();

  polyshift_r_unit #(.WORD_WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Independent reference: build the double-width extension and shift it in one step.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [W-2:0] c,
                                             input logic [2:0] s, input logic [1:0] t);
    logic [2*W-1:0] e;
    logic [2*W-1:0] sh;
    case (t)
      2'd0:    e = {{W{1'b0}}, d};
      2'd1:    e = {{W{d[W-1]}}, d};
      2'd2:    e = {1'b0, c, d};
      2'd3:    e = {d, d};
      default: e = {2*W{1'b0}};
    endcase
    sh = e >> s;
    return sh[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] d, input logic [W-2:0] c, input logic [2:0] s,
                       input logic [1:0] t, input logic [W-1:0] exp);
    bus.d_i          = d;
    bus.c_i          = c;
    bus.shift_size_i = s;
    bus.shift_type_i = t;
    bus.valid_i      = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1 && bus.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected valid_o: got d_o=%b with no expected result", bus.d_o);
        end else begin
          check("scoreboard d_o", bus.d_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d0;
    logic [W-2:0] c0;
    int           waited;
    d0 = 8'b1011_0010;
    c0 = 7'b101_0101;
    rst_ni           = 1'b0;
    bus.d_i          = 8'h00;
    bus.c_i          = 7'h00;
    bus.shift_size_i = 3'd0;
    bus.shift_type_i = 2'd0;
    bus.valid_i      = 1'b0;

    #3;
    check("reset d_o", bus.d_o, 8'h00);
    check("reset valid_o", {7'b0, bus.valid_o}, 8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full sweep against the reference model, back to back.
    for (int t = 0; t < 4; t++) begin
      for (int s = 0; s < 8; s++) begin
        issue(d0, c0, 3'(s), 2'(t), ref_shift(d0, c0, 3'(s), 2'(t)));
      end
    end

    // Hand-computed points at s=0, s=3 and s=7.
    issue(d0, c0, 3'd0, 2'd3, 8'b1011_0010);
    issue(d0, c0, 3'd3, 2'd0, 8'b0001_0110);
    issue(d0, c0, 3'd3, 2'd1, 8'b1111_0110);
    issue(d0, c0, 3'd3, 2'd2, 8'b1011_0110);
    issue(d0, c0, 3'd3, 2'd3, 8'b0101_0110);
    issue(8'b0111_0010, c0, 3'd7, 2'd1, 8'b0000_0000);
    issue(8'b1000_0000, c0, 3'd7, 2'd1, 8'b1111_1111);
    issue(8'b1000_0001, c0, 3'd7, 2'd3, 8'b0000_0011);
    issue(d0, c0, 3'd7, 2'd2, 8'b1010_1011);

    // Four back-to-back operations with differing operands, then an idle cycle.
    issue(8'hF0, 7'h00, 3'd4, 2'd0, 8'h0F);
    issue(8'h81, 7'h00, 3'd1, 2'd3, 8'hC0);
    issue(8'h90, 7'h00, 3'd2, 2'd1, 8'hE4);
    issue(8'h01, 7'h7F, 3'd1, 2'd2, 8'h80);
    bus.valid_i = 1'b0;
    bus.d_i     = 8'h55;
    @(posedge clk_i);
    #1;
    check("idle valid_o", {7'b0, bus.valid_o}, 8'h00);
    check("idle d_o hold", bus.d_o, 8'h80);

    // Asynchronous reset between edges after an accepted operation.
    issue(8'hA5, 7'h00, 3'd1, 2'd0, 8'h52);
    bus.valid_i = 1'b0;
    #6;
    check("pre-reset d_o", bus.d_o, 8'h52);
    rst_ni = 1'b0;
    #1;
    check("async reset d_o", bus.d_o, 8'h00);
    check("async reset valid_o", {7'b0, bus.valid_o}, 8'h00);
    bus.d_i          = 8'hFF;
    bus.shift_size_i = 3'd2;
    bus.shift_type_i = 2'd0;
    bus.valid_i      = 1'b1;
    @(posedge clk_i);
    #1;
    check("in-reset valid_o", {7'b0, bus.valid_o}, 8'h00);
    check("in-reset d_o", bus.d_o, 8'h00);
    rst_ni = 1'b1;
    issue(8'h96, 7'h00, 3'd2, 2'd1, 8'hE5);
    bus.valid_i = 1'b0;

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk_i);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
